// File: rtl/wb_dmem_master_pkg.sv
// Shared definitions for the data-memory Wishbone master: bus widths, access
// size codes, FSM state encoding, the registered request payload and the
// lane/byte-enable helpers used when a request is accepted.
package wb_dmem_master_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Request fields still needed after the bus cycle has been launched.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lane;
  } req_t;

  // Reserved size or an address not naturally aligned to the access size.
  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte enables for the addressed lanes.
  function automatic logic [SEL_W-1:0] lane_sel(input logic [1:0] size, input logic [1:0] lane);
    logic [SEL_W-1:0] sel;
    case (size)
      SZ_BYTE: sel = 4'b0001 << lane;
      SZ_HALF: sel = 4'b0011 << lane;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  // Store data replicated so every lane the slave may pick holds the value.
  function automatic logic [DATA_W-1:0] lane_data(input logic [1:0] size, input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] dat;
    case (size)
      SZ_BYTE: dat = {4{wdata[7:0]}};
      SZ_HALF: dat = {2{wdata[15:0]}};
      default: dat = wdata;
    endcase
    return dat;
  endfunction

endpackage

// File: rtl/wb_dmem_master_load_align.sv
// Load data alignment: shifts the addressed lane of the bus word down to bit 0
// and sign- or zero-extends it according to access size.
// Ports: size/is_unsigned/lane describe the access, data is the raw bus word,
// rdata_c is the extended result (combinational).
module load_align
  import wb_dmem_master_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] lane_word;

  always_comb begin
    lane_word = data >> {lane, 3'b000};
    case (size)
      SZ_BYTE: rdata_c = is_unsigned ? {24'h0, lane_word[7:0]}
                                     : {{24{lane_word[7]}}, lane_word[7:0]};
      SZ_HALF: rdata_c = is_unsigned ? {16'h0, lane_word[15:0]}
                                     : {{16{lane_word[15]}}, lane_word[15:0]};
      // Word accesses are always lane 0, so lane_word equals data here.
      default: rdata_c = lane_word;
    endcase
  end

endmodule

// File: rtl/wb_dmem_master.sv
// Core load/store port to Wishbone classic master bridge. One transfer at a
// time: accept in IDLE, run a single bus cycle in BUS (abort after TIMEOUT
// unacknowledged cycles), then pulse a response for one cycle in RESP.
// Ports: i_ck/i_rb clock and synchronous active-low reset; i_req_* / o_req_ready
// request handshake; o_rsp_* completion; o_wb_* / i_wb_* Wishbone master side.
module wb_dmem_master
  import wb_dmem_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              i_ck,
  input  logic              i_rb,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [SEL_W-1:0]  o_wb_sel,
  output logic [ADDR_W-1:0] o_wb_adr,
  output logic [DATA_W-1:0] o_wb_dat,
  input  logic [DATA_W-1:0] i_wb_dat,
  input  logic              i_wb_ack
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t            state, state_nxt;
  req_t              req_q, req_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [SEL_W-1:0]  sel_nxt;
  logic [ADDR_W-1:0] adr_nxt;
  logic [DATA_W-1:0] dat_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              err_nxt;
  logic [DATA_W-1:0] load_c;

  load_align u_load_align (
    .size        (req_q.size),
    .is_unsigned (req_q.uns),
    .lane        (req_q.lane),
    .data        (i_wb_dat),
    .rdata_c     (load_c)
  );

  // State and output registers; every bus/response output is a flop.
  always_ff @(posedge i_ck) begin
    if (!i_rb) begin
      state       <= IDLE;
      req_q       <= '0;
      cnt         <= '0;
      o_req_ready <= 1'b1;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_sel    <= '0;
      o_wb_adr    <= '0;
      o_wb_dat    <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_rdata <= '0;
    end else begin
      state       <= state_nxt;
      req_q       <= req_nxt;
      cnt         <= cnt_nxt;
      o_req_ready <= (state_nxt == IDLE);
      o_wb_cyc    <= (state_nxt == BUS);
      o_wb_stb    <= (state_nxt == BUS);
      o_wb_we     <= req_nxt.we;
      o_wb_sel    <= sel_nxt;
      o_wb_adr    <= adr_nxt;
      o_wb_dat    <= dat_nxt;
      o_rsp_valid <= (state_nxt == RESP);
      o_rsp_err   <= err_nxt;
      o_rsp_rdata <= rdata_nxt;
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    cnt_nxt   = cnt;
    sel_nxt   = o_wb_sel;
    adr_nxt   = o_wb_adr;
    dat_nxt   = o_wb_dat;
    rdata_nxt = o_rsp_rdata;
    err_nxt   = o_rsp_err;

    case (state)
      IDLE: begin
        if (i_req_valid && o_req_ready) begin
          req_nxt.we   = i_req_we;
          req_nxt.size = i_req_size;
          req_nxt.uns  = i_req_unsigned;
          req_nxt.lane = i_req_addr[1:0];
          adr_nxt      = {i_req_addr[ADDR_W-1:2], 2'b00};
          sel_nxt      = lane_sel(i_req_size, i_req_addr[1:0]);
          dat_nxt      = lane_data(i_req_size, i_req_wdata);
          cnt_nxt      = CNT_W'(1);
          // Illegal accesses answer immediately without touching the bus.
          if (bad_access(i_req_size, i_req_addr[1:0])) begin
            state_nxt = RESP;
            err_nxt   = 1'b1;
            rdata_nxt = '0;
          end else begin
            state_nxt = BUS;
          end
        end
      end

      BUS: begin
        // An ack on the final allowed cycle still completes normally.
        if (i_wb_ack) begin
          state_nxt = RESP;
          err_nxt   = 1'b0;
          rdata_nxt = req_q.we ? '0 : load_c;
        end else if (cnt == TIMEOUT_CNT) begin
          state_nxt = RESP;
          err_nxt   = 1'b1;
          rdata_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      RESP: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_dmem_master.sv
// Directed bench for wb_dmem_master with a scripted Wishbone slave.
module tb_wb_dmem_master;
  import wb_dmem_master_pkg::*;

  logic        ck, rb;
  logic        req_valid, req_ready, req_we, req_uns;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;

  int checks   = 0;
  int failures = 0;

  // Results captured by wait_rsp
  int          lat;
  int          stb_cnt;
  logic [3:0]  seen_sel;
  logic [31:0] seen_adr, seen_dat;
  logic        seen_we;
  logic [31:0] got_rdata;
  logic        got_err, got_cyc;

  wb_dmem_master #(.TIMEOUT(15)) dut (
    .i_ck           (ck),
    .i_rb           (rb),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_size     (req_size),
    .i_req_unsigned (req_uns),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_err      (rsp_err),
    .o_wb_cyc       (wb_cyc),
    .o_wb_stb       (wb_stb),
    .o_wb_we        (wb_we),
    .o_wb_sel       (wb_sel),
    .o_wb_adr       (wb_adr),
    .o_wb_dat       (wb_dat_o),
    .i_wb_dat       (wb_dat_i),
    .i_wb_ack       (wb_ack)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_uns   = uns;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  // Called just after the accept edge; slave acks on its ack_delay-th stb cycle
  // (0 = never). lat counts cycles after accept until rsp_valid is seen.
  task automatic wait_rsp(input int ack_delay, input logic [31:0] sdata);
    logic done;
    done     = 1'b0;
    lat      = 1;
    stb_cnt  = 0;
    wb_dat_i = sdata;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        done = 1'b1;
        break;
      end
      if (wb_stb) begin
        stb_cnt++;
        seen_sel = wb_sel;
        seen_adr = wb_adr;
        seen_dat = wb_dat_o;
        seen_we  = wb_we;
      end
      wb_ack = wb_stb && (ack_delay != 0) && (stb_cnt == ack_delay);
      tick();
      lat++;
    end
    wb_ack = 1'b0;
    chk("rsp_seen", 32'(done), 32'd1);
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    got_cyc   = wb_cyc;
  endtask

  task automatic xfer(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int ack_delay, input logic [31:0] sdata);
    drive_req(we, size, uns, addr, wdata);
    tick();
    req_valid = 1'b0;
    wait_rsp(ack_delay, sdata);
  endtask

  // Cycle after a response: pulse gone, result held, ready for the next request.
  task automatic post_rsp(input string tag);
    tick();
    chk({tag, "_pulse_end"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_err_hold"}, 32'(rsp_err), 32'(got_err));
    chk({tag, "_rdata_hold"}, rsp_rdata, got_rdata);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rb = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_uns = 1'b0;
    req_addr = '0; req_wdata = '0; wb_ack = 1'b0; wb_dat_i = '0;
    seen_sel = '0; seen_adr = '0; seen_dat = '0; seen_we = 1'b0;
    got_rdata = '0; got_err = 1'b0; got_cyc = 1'b0; lat = 0; stb_cnt = 0;

    // Reset state
    tick(); tick();
    chk("rst_cyc", 32'(wb_cyc), 0);
    chk("rst_stb", 32'(wb_stb), 0);
    chk("rst_sel", 32'(wb_sel), 0);
    chk("rst_adr", wb_adr, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_ready", 32'(req_ready), 1);
    rb = 1'b1;
    tick();

    // Word store, ack on second stb cycle
    xfer(1'b1, SZ_WORD, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0);
    chk("ws_sel", 32'(seen_sel), 32'hF);
    chk("ws_adr", seen_adr, 32'h100);
    chk("ws_dat", seen_dat, 32'hDEAD_BEEF);
    chk("ws_we", 32'(seen_we), 1);
    chk("ws_stb_cycles", 32'(stb_cnt), 2);
    chk("ws_latency", 32'(lat), 3);
    chk("ws_err", 32'(got_err), 0);
    chk("ws_rdata", got_rdata, 0);
    post_rsp("ws");

    // Byte load lane 3, signed then unsigned
    xfer(1'b0, SZ_BYTE, 1'b0, 32'h0000_0103, 32'h0, 1, 32'h80FF_0000);
    chk("lbs_sel", 32'(seen_sel), 32'h8);
    chk("lbs_adr", seen_adr, 32'h100);
    chk("lbs_we", 32'(seen_we), 0);
    chk("lbs_latency", 32'(lat), 2);
    chk("lbs_rdata", got_rdata, 32'hFFFF_FF80);
    chk("lbs_err", 32'(got_err), 0);
    post_rsp("lbs");
    xfer(1'b0, SZ_BYTE, 1'b1, 32'h0000_0103, 32'h0, 1, 32'h80FF_0000);
    chk("lbu_rdata", got_rdata, 32'h0000_0080);
    post_rsp("lbu");

    // Half store upper lane, half load upper lane signed
    xfer(1'b1, SZ_HALF, 1'b0, 32'h0000_0202, 32'h0000_1234, 1, 32'h0);
    chk("hs_sel", 32'(seen_sel), 32'hC);
    chk("hs_dat", seen_dat, 32'h1234_1234);
    chk("hs_adr", seen_adr, 32'h200);
    post_rsp("hs");
    xfer(1'b0, SZ_HALF, 1'b0, 32'h0000_0202, 32'h0, 1, 32'h80FF_0000);
    chk("lh_rdata", got_rdata, 32'hFFFF_80FF);
    post_rsp("lh");

    // Misaligned half load and reserved size: immediate error, no bus cycle
    xfer(1'b0, SZ_HALF, 1'b0, 32'h0000_0201, 32'h0, 1, 32'h1234_5678);
    chk("mis_stb_cycles", 32'(stb_cnt), 0);
    chk("mis_latency", 32'(lat), 1);
    chk("mis_err", 32'(got_err), 1);
    chk("mis_rdata", got_rdata, 0);
    post_rsp("mis");
    xfer(1'b0, SZ_RSVD, 1'b0, 32'h0000_0100, 32'h0, 1, 32'h1234_5678);
    chk("rsv_stb_cycles", 32'(stb_cnt), 0);
    chk("rsv_err", 32'(got_err), 1);
    post_rsp("rsv");

    // Word load, then timeout clears a nonzero previous rdata
    xfer(1'b0, SZ_WORD, 1'b0, 32'h0000_0104, 32'h0, 1, 32'h1234_5678);
    chk("lw_adr", seen_adr, 32'h104);
    chk("lw_rdata", got_rdata, 32'h1234_5678);
    chk("lw_err", 32'(got_err), 0);
    post_rsp("lw");
    xfer(1'b0, SZ_WORD, 1'b0, 32'h0000_0108, 32'h0, 0, 32'hFFFF_FFFF);
    chk("to_stb_cycles", 32'(stb_cnt), 15);
    chk("to_latency", 32'(lat), 16);
    chk("to_cyc_low", 32'(got_cyc), 0);
    chk("to_err", 32'(got_err), 1);
    chk("to_rdata", got_rdata, 0);
    post_rsp("to");

    // Reset in the middle of a bus cycle
    xfer(1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hAABB_CCDD);
    chk("pre_rst_rdata", got_rdata, 32'hAABB_CCDD);
    post_rsp("pre_rst");
    drive_req(1'b0, SZ_WORD, 1'b0, 32'h0000_0300, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("mr_stb1", 32'(wb_stb), 1);
    tick();
    chk("mr_stb2", 32'(wb_stb), 1);
    rb = 1'b0;
    tick();
    chk("mr_cyc", 32'(wb_cyc), 0);
    chk("mr_stb", 32'(wb_stb), 0);
    chk("mr_rsp_valid", 32'(rsp_valid), 0);
    chk("mr_rdata", rsp_rdata, 0);
    rb = 1'b1;
    wb_dat_i = 32'h5555_5555;
    wb_ack = 1'b1;
    tick();
    chk("mr_late_ack_rsp", 32'(rsp_valid), 0);
    chk("mr_late_ack_cyc", 32'(wb_cyc), 0);
    wb_ack = 1'b0;
    tick();
    chk("mr_late_ack_rsp2", 32'(rsp_valid), 0);
    chk("mr_ready", 32'(req_ready), 1);
    xfer(1'b0, SZ_WORD, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0BAD_F00D);
    chk("mr_next_rdata", got_rdata, 32'h0BAD_F00D);
    chk("mr_next_latency", 32'(lat), 2);
    post_rsp("mr_next");

    // Back-to-back with request valid held high
    drive_req(1'b0, SZ_WORD, 1'b0, 32'h0000_0020, 32'h0);
    tick();
    wait_rsp(1, 32'h1111_1111);
    chk("b2b_first_rdata", got_rdata, 32'h1111_1111);
    tick();
    chk("b2b_gap_rsp", 32'(rsp_valid), 0);
    chk("b2b_gap_ready", 32'(req_ready), 1);
    chk("b2b_gap_stb", 32'(wb_stb), 0);
    tick();
    req_valid = 1'b0;
    chk("b2b_second_accept", 32'(wb_stb), 1);
    wait_rsp(1, 32'h2222_2222);
    chk("b2b_second_rdata", got_rdata, 32'h2222_2222);
    post_rsp("b2b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
